pipeline_stall_ctrl: RTL and testbench

Parametrised pipeline stall, flush and bubble controller for the MIRI pipelined core. It sits beside the decode stage and drives the per-stage latch enables (EN_REG_FETCH/DECODE/ALU/MEM). Sources it arbitrates:
- instruction-cache and data-cache block requests;
- load-use hazards;
- taken branches;
- multi-cycle multiplies, with a configurable latency the single-cycle control unit cannot express.

It also keeps saturating stall and flush statistics counters.

---
 rtl/pipeline_stall_ctrl_if.sv | 71 +++++++
 rtl/pipeline_stall_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_stall_ctrl_if
//
// Purpose: bundles the decode/ALU hazard information, cache block requests,
// the per-stage latch enables and the statistics counters exchanged between
// the MIRI pipeline and its stall/flush controller.
//
// Signal names carry the controller's point of view: i_* are driven by the
// pipeline (master) and read by the controller (slave); o_* go the other way.
//
//   i_dec_reg_a/b          source registers of the instruction in decode
//   i_dec_use_a/b          source register is actually read
//   i_dec_is_mul           decode holds a multiply
//   i_alu_reg_d            destination register of the instruction in ALU
//   i_alu_mem_r            instruction in ALU is a load
//   i_branch_taken         branch resolved taken in ALU this cycle
//   i_block_pipe_*_cache   cache miss in progress
//   o_en_reg_*             per-stage latch enables
//   o_injecting_nop        first frozen/flushed stage's successor loads NOP
//   o_inject_nop           NOP encoding
//   o_flush                fetch and decode latches load NOP this cycle
//   o_mul_busy             multiply occupying the ALU
//   o_stall_cycles         saturating count of cycles with fetch frozen
//   o_flush_count          saturating count of flush cycles
// ----------------------------------------------------------------------------
interface pipeline_stall_ctrl_if #(
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned CNT_W     = 16
);
    logic [REG_IDX_W-1:0] i_dec_reg_a;
    logic [REG_IDX_W-1:0] i_dec_reg_b;
    logic                 i_dec_use_a;
    logic                 i_dec_use_b;
    logic                 i_dec_is_mul;
    logic [REG_IDX_W-1:0] i_alu_reg_d;
    logic                 i_alu_mem_r;
    logic                 i_branch_taken;
    logic                 i_block_pipe_instr_cache;
    logic                 i_block_pipe_data_cache;

    logic                 o_en_reg_fetch;
    logic                 o_en_reg_decode;
    logic                 o_en_reg_alu;
    logic                 o_en_reg_mem;
    logic                 o_injecting_nop;
    logic [31:0]          o_inject_nop;
    logic                 o_flush;
    logic                 o_mul_busy;
    logic [CNT_W-1:0]     o_stall_cycles;
    logic [CNT_W-1:0]     o_flush_count;

    // Pipeline side.
    modport master (
        output i_dec_reg_a, i_dec_reg_b, i_dec_use_a, i_dec_use_b, i_dec_is_mul,
        output i_alu_reg_d, i_alu_mem_r, i_branch_taken,
        output i_block_pipe_instr_cache, i_block_pipe_data_cache,
        input  o_en_reg_fetch, o_en_reg_decode, o_en_reg_alu, o_en_reg_mem,
        input  o_injecting_nop, o_inject_nop, o_flush, o_mul_busy,
        input  o_stall_cycles, o_flush_count
    );

    // Controller side.
    modport slave (
        input  i_dec_reg_a, i_dec_reg_b, i_dec_use_a, i_dec_use_b, i_dec_is_mul,
        input  i_alu_reg_d, i_alu_mem_r, i_branch_taken,
        input  i_block_pipe_instr_cache, i_block_pipe_data_cache,
        output o_en_reg_fetch, o_en_reg_decode, o_en_reg_alu, o_en_reg_mem,
        output o_injecting_nop, o_inject_nop, o_flush, o_mul_busy,
        output o_stall_cycles, o_flush_count
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Purpose: stall, flush and bubble controller for the MIRI pipelined core.
// Drives the fetch/decode/ALU/MEM latch enables from cache block requests,
// load-use hazards, taken branches and multi-cycle multiplies, and keeps
// saturating stall/flush statistics.
//
// Ports:
//   i_clk    single clock, all state on the rising edge
//   i_reset  synchronous, active-high reset
//   bus      pipeline_stall_ctrl_if.slave (hazard inputs, enables, statistics)
//
// Parameters:
//   REG_IDX_W  register index width
//   MUL_LAT    ALU occupancy of one multiply in cycles (>= 1)
//   CNT_W      statistics counter width
//   NOP_INSTR  encoding presented on o_inject_nop
//
// All enables/flags are combinational from state and inputs (zero latency).
// Priority, highest first: reset, data-cache block, multiply busy, taken
// branch, load-use hazard, instruction-cache block, normal run.
// ----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned MUL_LAT   = 5,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    pipeline_stall_ctrl_if.slave  bus
);

    localparam int unsigned       MulCntW     = $clog2(MUL_LAT) + 1;
    localparam logic [MulCntW-1:0] MulIssueCnt = MulCntW'(MUL_LAT - 1);
    // A single-cycle multiply fits the normal pipeline flow.
    localparam bit                MulStalls   = (MUL_LAT > 1);

    typedef enum logic [0:0] {
        StRun,
        StMulBusy
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [MulCntW-1:0]   r_mul_cnt;
    logic [MulCntW-1:0]   w_mul_cnt_next;
    logic [CNT_W-1:0]     r_stall_cycles;
    logic [CNT_W-1:0]     r_flush_count;

    logic                 w_load_use;
    logic                 w_en_fetch;
    logic                 w_en_decode;
    logic                 w_en_alu;
    logic                 w_en_mem;
    logic                 w_injecting_nop;
    logic                 w_flush;

    // r0 is deliberately not exempt: a load to r0 still stalls a reader.
    assign w_load_use = bus.i_alu_mem_r &&
                        ((bus.i_dec_use_a && (bus.i_dec_reg_a == bus.i_alu_reg_d)) ||
                         (bus.i_dec_use_b && (bus.i_dec_reg_b == bus.i_alu_reg_d)));

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_en_fetch      = 1'b1;
        w_en_decode     = 1'b1;
        w_en_alu        = 1'b1;
        w_en_mem        = 1'b1;
        w_injecting_nop = 1'b0;
        w_flush         = 1'b0;
        w_state_next    = r_state;
        w_mul_cnt_next  = r_mul_cnt;

        if (i_reset) begin
            w_en_fetch  = 1'b0;
            w_en_decode = 1'b0;
            w_en_alu    = 1'b0;
            w_en_mem    = 1'b0;
            w_state_next   = StRun;
            w_mul_cnt_next = '0;
        end else if (bus.i_block_pipe_data_cache) begin
            // Whole pipe frozen; a multiply in flight keeps its count.
            w_en_fetch  = 1'b0;
            w_en_decode = 1'b0;
            w_en_alu    = 1'b0;
            w_en_mem    = 1'b0;
        end else if (r_state == StMulBusy) begin
            // Multiply holds the ALU; MEM drains and receives a bubble.
            // A taken branch here is a protocol violation and is ignored.
            w_en_fetch      = 1'b0;
            w_en_decode     = 1'b0;
            w_en_alu        = 1'b0;
            w_injecting_nop = 1'b1;
            if (r_mul_cnt <= MulCntW'(1)) begin
                w_state_next   = StRun;
                w_mul_cnt_next = '0;
            end else begin
                w_mul_cnt_next = r_mul_cnt - MulCntW'(1);
            end
        end else if (bus.i_branch_taken) begin
            // Both younger stages are squashed on the same edge.
            w_flush         = 1'b1;
            w_injecting_nop = 1'b1;
        end else if (w_load_use) begin
            // Hold the consumer in decode one cycle; bubble into ALU.
            w_en_fetch      = 1'b0;
            w_en_decode     = 1'b0;
            w_injecting_nop = 1'b1;
        end else begin
            if (bus.i_block_pipe_instr_cache) begin
                // Only fetch waits; decode still advances and receives a NOP.
                w_en_fetch      = 1'b0;
                w_injecting_nop = 1'b1;
            end
            // Multiply moves into the ALU this edge and occupies it afterwards.
            if (MulStalls && bus.i_dec_is_mul) begin
                w_state_next   = StMulBusy;
                w_mul_cnt_next = MulIssueCnt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State and statistics registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= StRun;
            r_mul_cnt      <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_mul_cnt <= w_mul_cnt_next;
            if (!w_en_fetch && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_flush && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.o_en_reg_fetch  = w_en_fetch;
    assign bus.o_en_reg_decode = w_en_decode;
    assign bus.o_en_reg_alu    = w_en_alu;
    assign bus.o_en_reg_mem    = w_en_mem;
    assign bus.o_injecting_nop = w_injecting_nop;
    assign bus.o_flush         = w_flush;
    assign bus.o_inject_nop    = NOP_INSTR;
    // Forced low while reset is asserted so no flag leaks during reset.
    assign bus.o_mul_busy      = (r_state == StMulBusy) && !i_reset;
    assign bus.o_stall_cycles  = r_stall_cycles;
    assign bus.o_flush_count   = r_flush_count;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Two controllers share one stimulus stream: one with a 5-cycle multiply and
// 16-bit counters, one with a single-cycle multiply and 3-bit counters. The
// reference model tracks remaining multiply cycles and counter values as
// plain integers; expected responses are queued per cycle and a monitor on
// the falling edge compares them with what the DUTs present.
// ----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    localparam int unsigned RW   = 5;
    localparam int unsigned LAT0 = 5;
    localparam int unsigned CW0  = 16;
    localparam int unsigned LAT1 = 1;
    localparam int unsigned CW1  = 3;
    localparam logic [31:0] NOP0 = 32'h0000_0013;
    localparam logic [31:0] NOP1 = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [RW-1:0] s_reg_a, s_reg_b, s_reg_d;
    logic          s_use_a, s_use_b, s_mul, s_mem_r, s_br, s_ic, s_dc;

    pipeline_stall_ctrl_if #(.REG_IDX_W(RW), .CNT_W(CW0)) bus0 ();
    pipeline_stall_ctrl_if #(.REG_IDX_W(RW), .CNT_W(CW1)) bus1 ();

    assign bus0.i_dec_reg_a = s_reg_a;
    assign bus0.i_dec_reg_b = s_reg_b;
    assign bus0.i_dec_use_a = s_use_a;
    assign bus0.i_dec_use_b = s_use_b;
    assign bus0.i_dec_is_mul = s_mul;
    assign bus0.i_alu_reg_d = s_reg_d;
    assign bus0.i_alu_mem_r = s_mem_r;
    assign bus0.i_branch_taken = s_br;
    assign bus0.i_block_pipe_instr_cache = s_ic;
    assign bus0.i_block_pipe_data_cache = s_dc;

    assign bus1.i_dec_reg_a = s_reg_a;
    assign bus1.i_dec_reg_b = s_reg_b;
    assign bus1.i_dec_use_a = s_use_a;
    assign bus1.i_dec_use_b = s_use_b;
    assign bus1.i_dec_is_mul = s_mul;
    assign bus1.i_alu_reg_d = s_reg_d;
    assign bus1.i_alu_mem_r = s_mem_r;
    assign bus1.i_branch_taken = s_br;
    assign bus1.i_block_pipe_instr_cache = s_ic;
    assign bus1.i_block_pipe_data_cache = s_dc;

    pipeline_stall_ctrl #(
        .REG_IDX_W(RW), .MUL_LAT(LAT0), .CNT_W(CW0), .NOP_INSTR(NOP0)
    ) dut0 (
        .i_clk(clk), .i_reset(rst), .bus(bus0)
    );

    pipeline_stall_ctrl #(
        .REG_IDX_W(RW), .MUL_LAT(LAT1), .CNT_W(CW1), .NOP_INSTR(NOP1)
    ) dut1 (
        .i_clk(clk), .i_reset(rst), .bus(bus1)
    );

    typedef struct {
        int unsigned inst;
        string       tag;
        bit          rst;
        logic [3:0]  en;     // {fetch, decode, alu, mem}
        logic        inj;
        logic        fl;
        logic        busy;
        int unsigned stall;
        int unsigned flc;
        logic [31:0] nop;
    } exp_t;

    exp_t sb_q[$];

    int unsigned m_busy  [2];   // remaining multiply freeze cycles
    int unsigned m_stall [2];
    int unsigned m_flc   [2];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // Expected response of instance k for the inputs currently driven, then
    // advance the model across the coming rising edge.
    task automatic model_step(input int unsigned k, input string tag);
        exp_t        e;
        int unsigned lat, cmax;
        bit          hz, mb;
        lat  = (k == 0) ? LAT0 : LAT1;
        cmax = (k == 0) ? (2 ** CW0 - 1) : (2 ** CW1 - 1);
        e.inst  = k;
        e.tag   = tag;
        e.rst   = rst;
        e.nop   = (k == 0) ? NOP0 : NOP1;
        e.stall = m_stall[k];
        e.flc   = m_flc[k];
        e.inj   = 1'b0;
        e.fl    = 1'b0;
        mb      = (m_busy[k] > 0);
        e.busy  = mb;
        hz = s_mem_r && ((s_use_a && s_reg_a == s_reg_d) || (s_use_b && s_reg_b == s_reg_d));
        if (rst) begin
            e.en       = 4'b0000;
            m_busy[k]  = 0;
            m_stall[k] = 0;
            m_flc[k]   = 0;
        end else begin
            if (s_dc) begin
                e.en = 4'b0000;
            end else if (mb) begin
                e.en  = 4'b0001;
                e.inj = 1'b1;
                m_busy[k] = m_busy[k] - 1;
            end else if (s_br) begin
                e.en  = 4'b1111;
                e.fl  = 1'b1;
                e.inj = 1'b1;
            end else if (hz) begin
                e.en  = 4'b0011;
                e.inj = 1'b1;
            end else begin
                e.en  = s_ic ? 4'b0111 : 4'b1111;
                e.inj = s_ic;
                if (s_mul && lat > 1) m_busy[k] = lat - 1;
            end
            if (!e.en[3] && m_stall[k] < cmax) m_stall[k] = m_stall[k] + 1;
            if (e.fl && m_flc[k] < cmax) m_flc[k] = m_flc[k] + 1;
        end
        sb_q.push_back(e);
    endtask

    task automatic cycle(input string tag);
        model_step(0, tag);
        model_step(1, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_reg_a = '0; s_reg_b = '0; s_reg_d = '0;
        s_use_a = 1'b0; s_use_b = 1'b0; s_mul = 1'b0; s_mem_r = 1'b0;
        s_br = 1'b0; s_ic = 1'b0; s_dc = 1'b0;
    endtask

    // Monitor: every cycle both DUTs present a response.
    always @(negedge clk) begin
        exp_t        e;
        logic [3:0]  a_en;
        logic        a_inj, a_fl, a_busy, ok;
        logic [31:0] a_nop;
        int unsigned a_stall, a_flc;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.inst == 0) begin
                a_en    = {bus0.o_en_reg_fetch, bus0.o_en_reg_decode,
                           bus0.o_en_reg_alu, bus0.o_en_reg_mem};
                a_inj   = bus0.o_injecting_nop;
                a_fl    = bus0.o_flush;
                a_busy  = bus0.o_mul_busy;
                a_nop   = bus0.o_inject_nop;
                a_stall = int'(bus0.o_stall_cycles);
                a_flc   = int'(bus0.o_flush_count);
            end else begin
                a_en    = {bus1.o_en_reg_fetch, bus1.o_en_reg_decode,
                           bus1.o_en_reg_alu, bus1.o_en_reg_mem};
                a_inj   = bus1.o_injecting_nop;
                a_fl    = bus1.o_flush;
                a_busy  = bus1.o_mul_busy;
                a_nop   = bus1.o_inject_nop;
                a_stall = int'(bus1.o_stall_cycles);
                a_flc   = int'(bus1.o_flush_count);
            end
            ok = (a_en === e.en) && (a_inj === e.inj) && (a_fl === e.fl) &&
                 (a_nop === e.nop);
            // Counters and mul_busy are only defined once reset has been sampled.
            if (!e.rst) begin
                ok = ok && (a_busy === e.busy) && (a_stall == e.stall) && (a_flc == e.flc);
            end
            n_vec = n_vec + 1;
            if (!ok) begin
                n_miss = n_miss + 1;
                $display("FAIL %s dut%0d t=%0t: got en=%b inj=%b flush=%b busy=%b stall=%0d flushes=%0d nop=%h; want en=%b inj=%b flush=%b busy=%b stall=%0d flushes=%0d nop=%h",
                         e.tag, e.inst, $time, a_en, a_inj, a_fl, a_busy, a_stall, a_flc,
                         a_nop, e.en, e.inj, e.fl, e.busy, e.stall, e.flc, e.nop);
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_stall[k] = 0; m_flc[k] = 0;
        end
        idle();
        rst = 1'b1;
        cycle("reset");
        cycle("reset");
        rst = 1'b0;
        repeat (3) cycle("idle_after_reset");

        // Load of r0 in ALU, decode reads r0 through B.
        s_mem_r = 1'b1; s_reg_d = '0; s_reg_b = '0; s_use_b = 1'b1; s_reg_a = 5'd7;
        cycle("load_use_r0");
        s_use_b = 1'b0;
        cycle("load_r0_unused");
        idle();
        cycle("idle");

        // Plain multiply.
        s_mul = 1'b1;
        cycle("mul_issue");
        s_mul = 1'b0;
        repeat (6) cycle("mul_busy");

        // Multiply with a 3-cycle data-cache block in the middle.
        s_mul = 1'b1;
        cycle("mul_issue_dc");
        s_mul = 1'b0;
        repeat (2) cycle("mul_busy_dc");
        s_dc = 1'b1;
        repeat (3) cycle("mul_dc_block");
        s_dc = 1'b0;
        repeat (4) cycle("mul_busy_dc_tail");

        // Taken branch wins over a simultaneous load-use match.
        s_mem_r = 1'b1; s_reg_d = 5'd3; s_reg_a = 5'd3; s_use_a = 1'b1; s_br = 1'b1;
        cycle("branch_over_load_use");
        idle();
        cycle("idle");

        // Both caches blocked, then instruction cache alone.
        s_dc = 1'b1; s_ic = 1'b1;
        repeat (10) cycle("both_caches");
        s_dc = 1'b0;
        repeat (2) cycle("icache_only");
        // Long instruction-cache block saturates the 3-bit counter.
        repeat (12) cycle("icache_saturate");
        idle();
        cycle("idle");

        // Reset in the middle of a multiply.
        s_mul = 1'b1;
        cycle("mul_issue_pre_reset");
        s_mul = 1'b0;
        cycle("mul_busy_pre_reset");
        rst = 1'b1;
        cycle("reset_mid_mul");
        rst = 1'b0;
        repeat (3) cycle("after_reset_mid_mul");

        // Randomised traffic; small register range so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            s_reg_a = RW'($urandom_range(3));
            s_reg_b = RW'($urandom_range(3));
            s_reg_d = RW'($urandom_range(3));
            s_use_a = ($urandom_range(1) == 0);
            s_use_b = ($urandom_range(1) == 0);
            s_mem_r = ($urandom_range(2) == 0);
            s_mul   = ($urandom_range(4) == 0);
            s_br    = ($urandom_range(9) == 0);
            s_ic    = ($urandom_range(7) == 0);
            s_dc    = ($urandom_range(11) == 0);
            rst     = ($urandom_range(199) == 0);
            cycle("random");
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_miss = n_miss + 1;
            $display("FAIL drain: %0d responses left unchecked, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
